// File: rtl/snd_cmd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: edge-detected strobes, latch or FIFO
// queue, debug status and a level or fixed-length pulse interrupt.
module snd_cmd_mailbox #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int MODE     = 1,
    parameter int IRQ_MODE = 0,
    parameter int IRQ_LEN  = 64
) (
    input  logic                         clk_49m,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    input  logic                         flush,
    input  logic                         ovf_clr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         irq_n
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              wr_q, rd_q;
    logic              wr_ev, rd_ev;
    logic              do_wr, do_pop, ovf_set, head_load;
    logic [DATA_W-1:0] head_val;
    logic [CNT_W-1:0]  count_nxt;

    // A flush swallows any coincident strobe event.
    assign wr_ev = wr_en & ~wr_q & ~flush;
    assign rd_ev = rd_en & ~rd_q & ~flush;

    assign empty = (count == '0);
    assign full  = (MODE == 1) ? (count == CNT_W'(DEPTH)) : ~empty;

    always_ff @(posedge clk_49m or negedge reset_n) begin
        if (!reset_n) begin
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            count    <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_q <= wr_en;
            rd_q <= rd_en;
            if (flush) begin
                count    <= '0;
                rd_data  <= '0;
                overflow <= 1'b0;
            end else begin
                count <= count_nxt;
                if (head_load) begin
                    rd_data <= head_val;
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end else if (ovf_clr) begin
                    overflow <= 1'b0;
                end
            end
        end
    end

    if (MODE == 1) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;

        // A pop frees a slot in the same cycle, so a full queue accepts write+pop.
        assign do_pop     = rd_ev & ~empty;
        assign do_wr      = wr_ev & (~full | do_pop);
        assign ovf_set    = wr_ev & ~do_wr;
        assign count_nxt  = count + CNT_W'(do_wr) - CNT_W'(do_pop);
        assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
        assign head_load  = (do_wr | do_pop) & (count_nxt != '0);
        // New head may be the entry being written this cycle.
        assign head_val   = (do_wr && (rd_ptr_nxt == wr_ptr)) ? wr_data : mem[rd_ptr_nxt];

        always_ff @(posedge clk_49m) begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
            end
        end

        always_ff @(posedge clk_49m or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(do_wr);
                rd_ptr <= rd_ptr_nxt;
            end
        end
    end else begin : g_latch
        assign do_pop    = rd_ev & ~empty;
        assign do_wr     = wr_ev;
        assign ovf_set   = wr_ev & ~empty & ~do_pop;
        assign count_nxt = do_wr ? CNT_W'(1) : (do_pop ? '0 : count);
        assign head_load = do_wr;
        assign head_val  = wr_data;
    end

    if (IRQ_MODE == 1) begin : g_pulse
        logic [7:0] irq_cnt;

        always_ff @(posedge clk_49m or negedge reset_n) begin
            if (!reset_n) begin
                irq_cnt <= 8'd0;
            end else if (flush) begin
                irq_cnt <= 8'd0;
            end else if (do_wr) begin
                irq_cnt <= 8'(IRQ_LEN);
            end else if (irq_cnt != 8'd0) begin
                irq_cnt <= irq_cnt - 8'd1;
            end
        end

        assign irq_n = (irq_cnt == 8'd0);
    end else begin : g_level
        assign irq_n = empty;
    end

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Bench for snd_cmd_mailbox: FIFO/level, latch/level and FIFO/pulse instances share
// one stimulus stream and are each compared every cycle against a queue model.
module tb_snd_cmd_mailbox;

    localparam int DEPTH = 4;
    localparam int LEN   = 64;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       flush;
    logic       ovf_clr;

    logic [7:0] o_rd    [3];
    logic       o_empty [3];
    logic       o_full  [3];
    logic [2:0] o_cnt   [3];
    logic       o_ovf   [3];
    logic       o_irq   [3];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, one slot per instance
    int         cfg_mode [3] = '{1, 0, 1};
    int         cfg_irq  [3] = '{0, 0, 1};
    logic [7:0] mq       [3][$];
    logic [7:0] m_head   [3];
    bit         m_ovf    [3];
    int         m_irq    [3];
    bit         m_pw, m_pr;

    snd_cmd_mailbox #(.DATA_W(8), .DEPTH(DEPTH), .MODE(1), .IRQ_MODE(0), .IRQ_LEN(LEN)) u_fifo (
        .clk_49m(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .flush(flush), .ovf_clr(ovf_clr), .rd_data(o_rd[0]), .empty(o_empty[0]), .full(o_full[0]),
        .count(o_cnt[0]), .overflow(o_ovf[0]), .irq_n(o_irq[0]));

    snd_cmd_mailbox #(.DATA_W(8), .DEPTH(DEPTH), .MODE(0), .IRQ_MODE(0), .IRQ_LEN(LEN)) u_latch (
        .clk_49m(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .flush(flush), .ovf_clr(ovf_clr), .rd_data(o_rd[1]), .empty(o_empty[1]), .full(o_full[1]),
        .count(o_cnt[1]), .overflow(o_ovf[1]), .irq_n(o_irq[1]));

    snd_cmd_mailbox #(.DATA_W(8), .DEPTH(DEPTH), .MODE(1), .IRQ_MODE(1), .IRQ_LEN(LEN)) u_pulse (
        .clk_49m(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .flush(flush), .ovf_clr(ovf_clr), .rd_data(o_rd[2]), .empty(o_empty[2]), .full(o_full[2]),
        .count(o_cnt[2]), .overflow(o_ovf[2]), .irq_n(o_irq[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_head[k] = 8'h00;
            m_ovf[k]  = 1'b0;
            m_irq[k]  = 0;
        end
        m_pw = 1'b1;
        m_pr = 1'b1;
    endfunction

    function automatic void model_step();
        bit we, re, popped, acc, oset;
        we   = wr_en && !m_pw;
        re   = rd_en && !m_pr;
        m_pw = wr_en;
        m_pr = rd_en;
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                mq[k].delete();
                m_head[k] = 8'h00;
                m_ovf[k]  = 1'b0;
                m_irq[k]  = 0;
                continue;
            end
            popped = 1'b0;
            acc    = 1'b0;
            oset   = 1'b0;
            if (re && mq[k].size() > 0) begin
                void'(mq[k].pop_front());
                popped = 1'b1;
            end
            if (we) begin
                if (cfg_mode[k] == 1) begin
                    if (mq[k].size() < DEPTH) begin
                        mq[k].push_back(wr_data);
                        acc = 1'b1;
                    end else begin
                        oset = 1'b1;
                    end
                end else begin
                    if (mq[k].size() != 0) oset = 1'b1;
                    mq[k].delete();
                    mq[k].push_back(wr_data);
                    acc = 1'b1;
                end
            end
            if ((acc || popped) && mq[k].size() != 0) m_head[k] = mq[k][0];
            if (ovf_clr) m_ovf[k] = 1'b0;
            if (oset) m_ovf[k] = 1'b1;
            if (acc) m_irq[k] = LEN;
            else if (m_irq[k] > 0) m_irq[k] = m_irq[k] - 1;
        end
    endfunction

    task automatic compare_all();
        int sz;
        for (int k = 0; k < 3; k++) begin
            sz = mq[k].size();
            chk($sformatf("d%0d_rd_data", k), o_rd[k], m_head[k]);
            chk($sformatf("d%0d_count", k), o_cnt[k], sz);
            chk($sformatf("d%0d_empty", k), o_empty[k], (sz == 0) ? 1 : 0);
            chk($sformatf("d%0d_full", k), o_full[k],
                (cfg_mode[k] == 1) ? ((sz == DEPTH) ? 1 : 0) : ((sz != 0) ? 1 : 0));
            chk($sformatf("d%0d_overflow", k), o_ovf[k], m_ovf[k]);
            chk($sformatf("d%0d_irq_n", k), o_irq[k],
                (cfg_irq[k] == 1) ? ((m_irq[k] == 0) ? 1 : 0) : ((sz == 0) ? 1 : 0));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_d%0d_rd_data", tag, k), o_rd[k], 0);
            chk($sformatf("%s_d%0d_count", tag, k), o_cnt[k], 0);
            chk($sformatf("%s_d%0d_empty", tag, k), o_empty[k], 1);
            chk($sformatf("%s_d%0d_full", tag, k), o_full[k], 0);
            chk($sformatf("%s_d%0d_overflow", tag, k), o_ovf[k], 0);
            chk($sformatf("%s_d%0d_irq_n", tag, k), o_irq[k], 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_wr(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d; tick();
        wr_en = 1'b0; tick();
    endtask

    task automatic do_rd();
        rd_en = 1'b1; tick();
        rd_en = 1'b0; tick();
    endtask

    task automatic do_both(input logic [7:0] d);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = d; tick();
        wr_en = 1'b0; rd_en = 1'b0; tick();
    endtask

    task automatic do_flush();
        flush = 1'b1; tick();
        flush = 1'b0; tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_n = 1'b1; wr_en = 1'b1; wr_data = 8'h00; rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();

        // Strobe held high through reset release must not write
        repeat (3) tick();
        chk("hold_count", o_cnt[0], 0);
        wr_en = 1'b0; tick();
        wr_en = 1'b1; wr_data = 8'h5A; tick();
        chk("first_wr_rd_data", o_rd[0], 8'h5A);
        chk("first_wr_count", o_cnt[0], 1);
        chk("first_wr_irq_n", o_irq[0], 0);
        wr_en = 1'b0; tick();

        // FIFO fill with overflow, then drain past empty
        do_flush();
        do_wr(8'h11); do_wr(8'h22); do_wr(8'h33); do_wr(8'h44); do_wr(8'h55);
        chk("fill_overflow", o_ovf[0], 1);
        repeat (5) do_rd();
        chk("drain_hold", o_rd[0], 8'h44);

        // Simultaneous write+pop on full and on empty
        do_flush();
        do_wr(8'h01); do_wr(8'h02); do_wr(8'h03); do_wr(8'h04);
        do_both(8'h99);
        chk("full_both_count", o_cnt[0], 4);
        repeat (4) do_rd();
        do_flush();
        do_both(8'h77);
        chk("empty_both_rd", o_rd[0], 8'h77);

        // Latch overwrite, pop and overflow clear
        do_flush();
        do_wr(8'hA0); do_wr(8'hA1);
        chk("latch_ovf", o_ovf[1], 1);
        do_rd();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();

        // Pulse interrupt length and retrigger
        do_flush();
        wr_en = 1'b1; wr_data = 8'hC1; tick();
        n = 1;
        for (int i = 1; i < 200; i++) begin
            wr_en = 1'b0; tick();
            if (o_irq[2]) break;
            n++;
        end
        chk("pulse_len", n, LEN);
        wr_en = 1'b1; wr_data = 8'hC2; tick();
        n = 1;
        for (int i = 1; i < 300; i++) begin
            wr_en = (i == 30); wr_data = 8'hC3; tick();
            if (o_irq[2]) break;
            n++;
        end
        chk("pulse_retrigger_len", n, 30 + LEN);
        wr_en = 1'b0;

        // Flush with coincident write
        do_flush();
        do_wr(8'h31); do_wr(8'h32); do_wr(8'h33);
        wr_en = 1'b1; wr_data = 8'h34; flush = 1'b1; tick();
        wr_en = 1'b0; flush = 1'b0; tick();
        chk("flush_count", o_cnt[0], 0);

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) begin
            do_wr(8'(8'hE0 + i));
            do_rd();
        end

        // Asynchronous reset mid-operation, strobe held through release
        do_wr(8'h42); do_wr(8'h43);
        wr_en = 1'b1; wr_data = 8'h44; tick();
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("midreset");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        repeat (2) tick();
        wr_en = 1'b0; tick();

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            rd_en   = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(0, 63) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
